// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU data port and the NIC DMA port.
// Optional stall/grant performance counters are enabled with DMEM_ARB_PERF_CNT_EN.
module dmem_arbiter #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_memEn,
    input  logic              cpu_memWrEn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              nic_req,
    input  logic              nic_wr,
    input  logic [ADDR_W-1:0] nic_addr,
    input  logic [DATA_W-1:0] nic_wdata,
    output logic              nic_gnt,
    output logic [DATA_W-1:0] nic_rdata,
    output logic              nic_rvalid,
`ifdef DMEM_ARB_PERF_CNT_EN
    output logic [31:0]       cpu_stall_cnt,
    output logic [31:0]       nic_gnt_cnt,
`endif
    output logic              mem_en,
    output logic              mem_wrEn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        PRI_CPU = 1'b0,
        PRI_NIC = 1'b1
    } pri_t;

    pri_t              pri, pri_nxt;
    pri_t              rd_tag, rd_tag_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              rd_pend, rd_pend_nxt;
    logic [DATA_W-1:0] cpu_hold, cpu_hold_nxt;
    logic              cpu_win, nic_win, contended, ret_ok, cpu_ret;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            pri      <= PRI_CPU;
            cnt      <= '0;
            rd_pend  <= 1'b0;
            rd_tag   <= PRI_CPU;
            cpu_hold <= '0;
        end else begin
            pri      <= pri_nxt;
            cnt      <= cnt_nxt;
            rd_pend  <= rd_pend_nxt;
            rd_tag   <= rd_tag_nxt;
            cpu_hold <= cpu_hold_nxt;
        end
    end

    // Grant, memory mux, burst accounting and read-return steering
    always_comb begin
        pri_nxt      = pri;
        cnt_nxt      = '0;
        rd_pend_nxt  = 1'b0;
        rd_tag_nxt   = rd_tag;
        cpu_hold_nxt = cpu_hold;
        mem_en       = 1'b0;
        mem_wrEn     = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        nic_rvalid   = 1'b0;
        nic_rdata    = '0;

        contended = cpu_memEn & nic_req;
        cpu_win   = cpu_memEn & (~nic_req | (pri == PRI_CPU));
        nic_win   = nic_req & (~cpu_memEn | (pri == PRI_NIC));
        cpu_stall = cpu_memEn & ~cpu_win;
        nic_gnt   = nic_win;
        cnt_inc   = cnt + CNT_W'(1);

        if (cpu_win) begin
            mem_en    = 1'b1;
            mem_wrEn  = cpu_memWrEn;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (nic_win) begin
            mem_en    = 1'b1;
            mem_wrEn  = nic_wr;
            mem_addr  = nic_addr;
            mem_wdata = nic_wdata;
        end

        // Under contention the priority owner always wins, so the burst grows
        if (contended) begin
            if (cnt_inc == CNT_W'(MAX_BURST)) begin
                pri_nxt = (pri == PRI_CPU) ? PRI_NIC : PRI_CPU;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt_inc;
            end
        end

        if (mem_en && !mem_wrEn) begin
            rd_pend_nxt = 1'b1;
            rd_tag_nxt  = cpu_win ? PRI_CPU : PRI_NIC;
        end

        // A reset in the return cycle discards the pending read
        ret_ok  = rd_pend & ~reset;
        cpu_ret = ret_ok & (rd_tag == PRI_CPU);
        if (ret_ok && rd_tag == PRI_NIC) begin
            nic_rvalid = 1'b1;
            nic_rdata  = mem_rdata;
        end
        if (cpu_ret) begin
            cpu_hold_nxt = mem_rdata;
        end
        cpu_rdata = cpu_ret ? mem_rdata : cpu_hold;
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    // Saturating activity counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_stall_cnt <= '0;
            nic_gnt_cnt   <= '0;
        end else begin
            if (cpu_stall && (cpu_stall_cnt != 32'hFFFF_FFFF)) begin
                cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
            end
            if (nic_gnt && (nic_gnt_cnt != 32'hFFFF_FFFF)) begin
                nic_gnt_cnt <= nic_gnt_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_memEn, cpu_memWrEn;
    logic [31:0] cpu_addr;
    logic [63:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        nic_req, nic_wr;
    logic [31:0] nic_addr;
    logic [63:0] nic_wdata, nic_rdata;
    logic        nic_gnt, nic_rvalid;
    logic        mem_en, mem_wrEn;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;
`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] cpu_stall_cnt, nic_gnt_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [63:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(64), .ADDR_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_memEn(cpu_memEn), .cpu_memWrEn(cpu_memWrEn), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .nic_req(nic_req), .nic_wr(nic_wr), .nic_addr(nic_addr), .nic_wdata(nic_wdata),
        .nic_gnt(nic_gnt), .nic_rdata(nic_rdata), .nic_rvalid(nic_rvalid),
`ifdef DMEM_ARB_PERF_CNT_EN
        .cpu_stall_cnt(cpu_stall_cnt), .nic_gnt_cnt(nic_gnt_cnt),
`endif
        .mem_en(mem_en), .mem_wrEn(mem_wrEn), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port memory: read data appears the cycle after the access
    always @(posedge clk) begin
        if (reset) begin
            mem[0]  <= 64'd1;
            mem[8]  <= 64'd2;
            mem[32] <= 64'hAA;
        end else if (mem_en) begin
            if (mem_wrEn) mem[mem_addr[7:0]] <= mem_wdata;
            else          mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic step(input logic ce, input logic cw, input logic [31:0] ca, input logic [63:0] cd,
                        input logic nr, input logic nw, input logic [31:0] na, input logic [63:0] nd);
        @(negedge clk);
        cpu_memEn = ce; cpu_memWrEn = cw; cpu_addr = ca; cpu_wdata = cd;
        nic_req = nr; nic_wr = nw; nic_addr = na; nic_wdata = nd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cpu_memEn = 0; cpu_memWrEn = 0; cpu_addr = 0; cpu_wdata = 0;
        nic_req = 0; nic_wr = 0; nic_addr = 0; nic_wdata = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (cpu_rdata !== 64'd0) begin bad++; $display("FAIL reset_cpu_rdata got=%h exp=0", cpu_rdata); end
        total++; if (nic_rvalid !== 1'b0 || nic_rdata !== 64'd0) begin bad++; $display("FAIL reset_nic got=%b/%h exp=0/0", nic_rvalid, nic_rdata); end
        total++; if (mem_en !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 64'd0) begin bad++; $display("FAIL reset_mem got=%b/%h/%h exp=0", mem_en, mem_addr, mem_wdata); end
        total++; if (cpu_stall !== 1'b0 || nic_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b/%b exp=0/0", cpu_stall, nic_gnt); end
    endtask

    task automatic test_cpu_only();
        step(1, 1, 32'h10, 64'h1122334455667788, 0, 0, 0, 0);
        total++; if (cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_wrEn !== 1'b1) begin bad++; $display("FAIL cpu_wr_ctl got=%b/%b/%b exp=0/1/1", cpu_stall, mem_en, mem_wrEn); end
        total++; if (mem_addr !== 32'h10 || mem_wdata !== 64'h1122334455667788) begin bad++; $display("FAIL cpu_wr_bus got=%h/%h exp=10/1122334455667788", mem_addr, mem_wdata); end
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        total++; if (cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_wrEn !== 1'b0) begin bad++; $display("FAIL cpu_rd_ctl got=%b/%b/%b exp=0/1/0", cpu_stall, mem_en, mem_wrEn); end
        total++; if (cpu_rdata !== 64'd0) begin bad++; $display("FAIL cpu_wr_noreturn got=%h exp=0", cpu_rdata); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (cpu_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL cpu_rd_data got=%h exp=1122334455667788", cpu_rdata); end
        total++; if (nic_rvalid !== 1'b0) begin bad++; $display("FAIL cpu_rd_nicvalid got=%b exp=0", nic_rvalid); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (cpu_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL cpu_rd_hold got=%h exp=1122334455667788", cpu_rdata); end
    endtask

    task automatic test_nic_only();
        step(0, 0, 0, 0, 1, 0, 32'h20, 0);
        total++; if (nic_gnt !== 1'b1 || cpu_stall !== 1'b0 || mem_addr !== 32'h20 || mem_wrEn !== 1'b0) begin bad++; $display("FAIL nic_rd_gnt got=%b/%b/%h/%b exp=1/0/20/0", nic_gnt, cpu_stall, mem_addr, mem_wrEn); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (nic_rvalid !== 1'b1 || nic_rdata !== 64'hAA) begin bad++; $display("FAIL nic_rd_data got=%b/%h exp=1/aa", nic_rvalid, nic_rdata); end
        total++; if (cpu_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL nic_rd_cpuhold got=%h exp=1122334455667788", cpu_rdata); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (nic_rvalid !== 1'b0 || nic_rdata !== 64'd0) begin bad++; $display("FAIL nic_rvalid_pulse got=%b/%h exp=0/0", nic_rvalid, nic_rdata); end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h8, 0);
        total++; if (cpu_rdata !== 64'd1 || nic_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_cpu got=%h/%b exp=1/0", cpu_rdata, nic_rvalid); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (nic_rvalid !== 1'b1 || nic_rdata !== 64'd2 || cpu_rdata !== 64'd1) begin bad++; $display("FAIL b2b_nic got=%b/%h/%h exp=1/2/1", nic_rvalid, nic_rdata, cpu_rdata); end
    endtask

    task automatic test_burst();
        logic cpu_turn;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 32'h0, 0, 1, 0, 32'h8, 0);
            cpu_turn = (i < 4) || (i >= 8);
            total++;
            if (cpu_stall !== !cpu_turn || nic_gnt !== !cpu_turn || mem_addr !== (cpu_turn ? 32'h0 : 32'h8)) begin
                bad++; $display("FAIL burst_cycle%0d got stall=%b gnt=%b addr=%h exp stall=%b", i, cpu_stall, nic_gnt, mem_addr, !cpu_turn);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_PERF_CNT_EN
        total++; if (cpu_stall_cnt !== 32'd4 || nic_gnt_cnt !== 32'd4) begin bad++; $display("FAIL perf_cnt got=%0d/%0d exp=4/4", cpu_stall_cnt, nic_gnt_cnt); end
`endif
        total++; if (mem_en !== 1'b0 || cpu_stall !== 1'b0 || nic_gnt !== 1'b0 || mem_addr !== 32'd0) begin bad++; $display("FAIL idle_outputs got=%b/%b/%b/%h exp=0", mem_en, cpu_stall, nic_gnt, mem_addr); end
        // Priority passed to the NIC at the end of the last CPU burst and survives the idle cycle
        step(1, 1, 32'h40, 64'h5, 1, 1, 32'h48, 64'h6);
        total++; if (nic_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_wdata !== 64'h6 || mem_wrEn !== 1'b1) begin bad++; $display("FAIL pri_kept got=%b/%b/%h exp=1/1/6", nic_gnt, cpu_stall, mem_wdata); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_drop();
        step(0, 0, 0, 0, 1, 0, 32'h20, 0);
        total++; if (nic_gnt !== 1'b1) begin bad++; $display("FAIL drop_gnt got=%b exp=1", nic_gnt); end
        @(negedge clk);
        reset = 1'b1;
        nic_req = 0;
        #1;
        total++; if (nic_rvalid !== 1'b0 || nic_rdata !== 64'd0) begin bad++; $display("FAIL drop_rvalid got=%b/%h exp=0/0", nic_rvalid, nic_rdata); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 32'h0, 0, 1, 0, 32'h8, 0);
            if (i == 0) begin
                total++; if (nic_rvalid !== 1'b0 || cpu_rdata !== 64'd0) begin bad++; $display("FAIL drop_after got=%b/%h exp=0/0", nic_rvalid, cpu_rdata); end
            end
            total++;
            if (nic_gnt !== (i == 4) || cpu_stall !== (i == 4)) begin
                bad++; $display("FAIL drop_pri%0d got gnt=%b stall=%b exp=%b", i, nic_gnt, cpu_stall, (i == 4));
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        cpu_memEn = 0; cpu_memWrEn = 0; cpu_addr = 0; cpu_wdata = 0;
        nic_req = 0; nic_wr = 0; nic_addr = 0; nic_wdata = 0;
        test_reset();
        test_cpu_only();
        test_nic_only();
        test_back_to_back();
        test_burst();
        test_reset_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU data port and the NIC DMA port of a ring node.
- Sits between the CPU EXMEM memory interface (memEn/memWrEn/addr_out/d_out/d_in) and the data memory.
- Grant is combinational, based on a registered priority/burst state. Losing CPU accesses are held off with cpu_stall. Read data returns one cycle after the access and is steered to the requester that issued it.

Parameters:
- DATA_W, 64, data width of all data buses
- ADDR_W, 32, address width
- MAX_BURST, 4, maximum consecutive grants to one requester while the other waits (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cpu_memEn  in  1  CPU memory access request
- cpu_memWrEn  in  1  CPU access is a write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data to CPU
- cpu_stall  out  1  CPU request not granted this cycle
- nic_req  in  1  NIC access request
- nic_wr  in  1  NIC access is a write
- nic_addr  in  ADDR_W  NIC address
- nic_wdata  in  DATA_W  NIC write data
- nic_gnt  out  1  NIC request granted this cycle
- nic_rdata  out  DATA_W  read data to NIC
- nic_rvalid  out  1  nic_rdata valid (one-cycle pulse)
- mem_en  out  1  memory enable
- mem_wrEn  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read

Behaviour:
Clock and reset:
- Single clock clk. reset is synchronous, active-high.
- On reset: pri <= CPU, cnt <= 0, rd_pend <= 0, rd_tag <= CPU, cpu_rdata hold register <= 0.
- Registered outputs therefore read 0. Combinational outputs are 0 while no request is present.

Priority FSM (pri), states PRI_CPU and PRI_NIC:
- Grant rules: only one requester → it wins. Both request → the requester named by pri wins. Neither → no grant.
- Memory outputs: mem_en = 1 on any grant. mem_wrEn, mem_addr and mem_wdata are muxed from the winner. All are 0 when there is no grant.
- cpu_stall = cpu_memEn & (winner != CPU). nic_gnt = nic_req & (winner == NIC). Both are combinational, with no added latency.

Burst counter (cnt, 4 bits):
- Winner == pri and the loser is also requesting: cnt increments. If the incremented value equals MAX_BURST, pri flips to the loser and cnt <= 0.
- Grant to the non-priority requester, or no contention: cnt <= 0 and pri is unchanged.
- With MAX_BURST=1, pri alternates on every contended cycle.

Read return:
- A granted read sets rd_pend <= 1 and rd_tag <= winner. Otherwise rd_pend <= 0.
- Next cycle, if rd_pend and rd_tag == NIC: nic_rvalid = 1 and nic_rdata = mem_rdata.
- If rd_pend and rd_tag == CPU: cpu_rdata = mem_rdata, and the hold register captures mem_rdata.
- Otherwise cpu_rdata = the hold register. It stays stable across stalls.
- nic_rdata = 0 whenever nic_rvalid = 0.
- Writes produce no return.

Boundary cases:
- Back-to-back reads from alternating owners are steered independently each cycle.
- Reset asserted with rd_pend = 1 drops the return: no nic_rvalid and no cpu_rdata update in the following cycle.
- A requester that deasserts while stalled or ungranted leaves no state behind.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- When defined, adds outputs cpu_stall_cnt (out, 32) and nic_gnt_cnt (out, 32).
  - cpu_stall_cnt increments on every cycle with cpu_stall = 1.
  - nic_gnt_cnt increments on every cycle with nic_gnt = 1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined, these ports and counters do not exist and the rest of the block behaves identically.

Test Plan:
- CPU only: write 0x1122334455667788 to 0x10, then read 0x10 → no cpu_stall; mem_en=1 on both cycles; cpu_rdata = 0x1122334455667788 on the cycle after the read, and held afterwards.
- NIC only: read 0x20 with memory preloaded to 0xAA → nic_gnt=1; next cycle nic_rvalid=1 and nic_rdata=0xAA; cpu_rdata unchanged.
- Both request continuously, MAX_BURST=4, after reset → grants go CPU×4, NIC×4, CPU×4. cpu_stall is high during exactly the 4 NIC cycles.
- Alternating reads: CPU reads 0x0 (data 1), then NIC reads 0x8 (data 2) → cpu_rdata=1 in cycle 2; nic_rvalid=1 with nic_rdata=2 in cycle 3.
- Reset pulsed the cycle after a granted NIC read → nic_rvalid stays 0; pri=CPU and cnt=0 afterwards.
- With DMEM_ARB_PERF_CNT_EN defined: the contended-traffic scenario above run for 12 cycles → cpu_stall_cnt=4 and nic_gnt_cnt=4.
